// File: rtl/fll_nco.sv
`default_nettype none
// ============================================================================
// Module      : fll_nco
// Description : Generator-side NCO of the frequency-locked loop. Integrates
//               the detector's signed period difference through a shift-gain
//               loop filter into a clamped tuning word, drives a 32-bit phase
//               accumulator and returns a triangle (or square) waveform.
//               An IDLE/ACQUIRE/LOCKED controller lowers loop gain on lock.
// Build macro : FLL_NCO_SQUARE_EN - square-wave output instead of triangle.
// Revision    : 1.0 - initial release
// ============================================================================
module fll_nco #(
  parameter logic [31:0] FTW_INIT       = 32'h0100_0000,
  parameter logic [31:0] FTW_MIN        = 32'h0000_1000,
  parameter logic [31:0] FTW_MAX        = 32'h4000_0000,
  parameter int          GAIN_SHIFT     = 8,
  parameter int          LOCK_SHIFT_ADD = 4,
  parameter int          LOCK_TOL       = 16,
  parameter int          LOCK_CNT       = 4
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               clk_en,
  input  logic               enabel,
  input  logic signed [31:0] delta,
  input  logic               delta_valid,
  output logic signed [31:0] signal_gen,
  output logic [31:0]        ftw,
  output logic               ftw_update,
  output logic               lock,
  output logic               sat
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int                 c_SHIFT_ACQ = GAIN_SHIFT;
  localparam int                 c_SHIFT_LCK = GAIN_SHIFT + LOCK_SHIFT_ADD;
  localparam logic signed [33:0] c_MIN34     = {2'b00, FTW_MIN};
  localparam logic signed [33:0] c_MAX34     = {2'b00, FTW_MAX};
  localparam logic [7:0]         c_LOCK_CNT  = 8'(LOCK_CNT);
  localparam logic [32:0]        c_TOL       = 33'(LOCK_TOL);
`ifdef FLL_NCO_SQUARE_EN
  localparam logic [31:0]        c_SIG_RESET = 32'h7FFF_FFFF;
`else
  localparam logic [31:0]        c_SIG_RESET = 32'h8000_0000;
`endif

  state_t             r_state, w_state_next;
  logic signed [31:0] r_delta, w_delta_next;
  logic               r_dv, w_dv_next;
  logic [31:0]        r_ftw, w_ftw_next;
  logic               r_upd, w_upd_next;
  logic               r_sat, w_sat_next;
  logic [7:0]         r_cnt, w_cnt_next;
  logic [31:0]        r_phase, w_phase_next;
  logic [31:0]        r_sig, w_wave;

  logic signed [31:0] w_corr;
  logic signed [33:0] w_sum;
  logic [31:0]        w_clamped;
  logic               w_clamp;
  logic [32:0]        w_abs;
  logic               w_in_tol;
  logic [7:0]         w_cnt_inc;

  // Loop filter: gain shift by state, 34-bit sum, clamp, tolerance counter.
  always_comb begin
    w_corr    = (r_state == ST_LOCKED) ? (r_delta >>> c_SHIFT_LCK)
                                       : (r_delta >>> c_SHIFT_ACQ);
    w_sum     = {2'b00, r_ftw} + {{2{w_corr[31]}}, w_corr};
    w_clamped = w_sum[31:0];
    w_clamp   = 1'b0;
    if (w_sum < c_MIN34) begin
      w_clamped = FTW_MIN;
      w_clamp   = 1'b1;
    end else if (w_sum > c_MAX34) begin
      w_clamped = FTW_MAX;
      w_clamp   = 1'b1;
    end
    // 33-bit magnitude so that -2^31 maps to +2^31 rather than wrapping.
    w_abs     = r_delta[31] ? (33'd0 - {r_delta[31], r_delta}) : {1'b0, r_delta};
    w_in_tol  = (w_abs <= c_TOL);
    w_cnt_inc = (r_cnt >= c_LOCK_CNT) ? c_LOCK_CNT : (r_cnt + 8'd1);
  end

  // Output waveform derived from the current phase.
  always_comb begin
`ifdef FLL_NCO_SQUARE_EN
    w_wave = r_phase[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
`else
    logic [30:0] w_tri;
    w_tri  = r_phase[31] ? ~r_phase[30:0] : r_phase[30:0];
    w_wave = {w_tri, 1'b0} - 32'h8000_0000;
`endif
  end

  // Controller next-state, tuning-word update and phase advance.
  always_comb begin
    w_state_next = r_state;
    w_delta_next = r_delta;
    w_dv_next    = 1'b0;
    w_ftw_next   = r_ftw;
    w_upd_next   = 1'b0;
    w_sat_next   = r_sat;
    w_cnt_next   = r_cnt;
    w_phase_next = r_phase;
    if (!enabel || (r_state == ST_IDLE)) begin
      // Loop disabled (or just enabled): park everything at its start value.
      // A strobe coinciding with enabel low is dropped here.
      w_state_next = enabel ? ST_ACQUIRE : ST_IDLE;
      w_ftw_next   = FTW_INIT;
      w_sat_next   = 1'b0;
      w_cnt_next   = 8'd0;
      w_phase_next = 32'd0;
    end else begin
      w_phase_next = r_phase + r_ftw;
      w_dv_next    = delta_valid;
      if (delta_valid) begin
        w_delta_next = delta;
      end
      if (r_dv) begin
        w_ftw_next = w_clamped;
        w_upd_next = 1'b1;
        w_sat_next = w_clamp;
        w_cnt_next = w_in_tol ? w_cnt_inc : 8'd0;
        if ((r_state == ST_ACQUIRE) && w_in_tol && (w_cnt_inc == c_LOCK_CNT)) begin
          w_state_next = ST_LOCKED;
        end else if ((r_state == ST_LOCKED) && !w_in_tol) begin
          w_state_next = ST_ACQUIRE;
        end
      end
    end
  end

  // State and datapath registers; clk_en low freezes every one of them.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_delta <= 32'sd0;
      r_dv    <= 1'b0;
      r_ftw   <= FTW_INIT;
      r_upd   <= 1'b0;
      r_sat   <= 1'b0;
      r_cnt   <= 8'd0;
      r_phase <= 32'd0;
      r_sig   <= c_SIG_RESET;
    end else if (clk_en) begin
      r_state <= w_state_next;
      r_delta <= w_delta_next;
      r_dv    <= w_dv_next;
      r_ftw   <= w_ftw_next;
      r_upd   <= w_upd_next;
      r_sat   <= w_sat_next;
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
      r_sig   <= w_wave;
    end
  end

  assign signal_gen = r_sig;
  assign ftw        = r_ftw;
  assign ftw_update = r_upd;
  assign lock       = (r_state == ST_LOCKED);
  assign sat        = r_sat;

endmodule
`default_nettype wire
